// File: rtl/icache_fill_pkg.sv
// Shared types and constants for the instruction-cache block fill path.
package icache_fill_pkg;

  typedef logic [2:0] fill_state_t;

  localparam fill_state_t ST_IDLE  = 3'd0;
  localparam fill_state_t ST_REQ   = 3'd1;
  localparam fill_state_t ST_WAIT  = 3'd2;
  localparam fill_state_t ST_DRAIN = 3'd3;
  localparam fill_state_t ST_DONE  = 3'd4;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_OFF_W = $clog2(WORD_BYTES);

  // Byte-offset width of a block holding the given number of words.
  function automatic int unsigned blk_off_w(input int unsigned words);
    return $clog2(words) + WORD_OFF_W;
  endfunction

endpackage

// File: rtl/icache_fill_ctlr_word_ctr.sv
// Word index / words-written counter for a block fill (module fill_word_ctr).
module fill_word_ctr #(
  parameter int unsigned WORDS = 16,
  parameter int unsigned IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [IDX_W-1:0] start_idx,
  input  logic             advance,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] cnt_q;

  // idx wraps naturally because WORDS is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      idx_q <= start_idx;
      cnt_q <= '0;
    end else if (advance) begin
      idx_q <= idx_q + IDX_W'(1);
      cnt_q <= cnt_q + IDX_W'(1);
    end
  end

  assign idx  = idx_q;
  assign last = (cnt_q == IDX_W'(WORDS - 1));

endmodule

// File: rtl/icache_fill_ctlr.sv
// L1 instruction-cache miss fill controller: fetches a block word by word and writes it into the cache.
// Optional critical-word-first ordering is enabled by defining ICACHE_CRIT_WORD_FIRST_EN.
module icache_fill_ctlr
  import icache_fill_pkg::*;
#(
  parameter int unsigned WORDS  = 16,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       InstrMissF,
  input  logic [ADDR_W-1:0]          MissAddrF,
  input  logic                       FlushFill,
  output logic                       MemReq,
  output logic [ADDR_W-1:0]          MemAddr,
  input  logic                       MemReady,
  input  logic                       MemRspValid,
  input  logic [31:0]                MemRspData,
  output logic                       FillWe,
  output logic [$clog2(WORDS)-1:0]   FillWordIdx,
  output logic [31:0]                FillData,
  output logic [ADDR_W-1:0]          FillTagAddr,
  output logic                       FillDone,
  output logic                       FillBusy
);

  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned OFF_W = blk_off_w(WORDS);

  fill_state_t       state_q;
  fill_state_t       state_d;
  logic [ADDR_W-1:0] tag_q;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  start_idx;
  logic              last;
  logic              load;
  logic              advance;
  logic              fill_we;
  logic              unused_miss_off;

  assign load = (state_q == ST_IDLE) && InstrMissF && !FlushFill;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
  assign start_idx = MissAddrF[OFF_W-1:WORD_OFF_W];
`else
  assign start_idx = '0;
`endif

  assign unused_miss_off = ^MissAddrF[OFF_W-1:0];

  fill_word_ctr #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_word_ctr (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .start_idx (start_idx),
    .advance   (advance),
    .idx       (idx),
    .last      (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Block-aligned tag captured once per miss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q <= '0;
    end else if (load) begin
      tag_q <= {MissAddrF[ADDR_W-1:OFF_W], OFF_W'(0)};
    end
  end

  // Next state; a flush either withdraws an unaccepted request or drains the one in flight.
  always_comb begin
    state_d = state_q;
    fill_we = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (FlushFill)     state_d = MemReady ? ST_DRAIN : ST_IDLE;
        else if (MemReady) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (FlushFill) begin
          state_d = MemRspValid ? ST_IDLE : ST_DRAIN;
        end else if (MemRspValid) begin
          fill_we = 1'b1;
          advance = 1'b1;
          state_d = last ? ST_DONE : ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (MemRspValid) state_d = ST_IDLE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode the state register so an async reset clears them at once.
  assign MemReq      = (state_q == ST_REQ);
  assign MemAddr     = MemReq ? {tag_q[ADDR_W-1:OFF_W], idx, WORD_OFF_W'(0)} : '0;
  assign FillWe      = fill_we;
  assign FillWordIdx = fill_we ? idx : '0;
  assign FillData    = fill_we ? MemRspData : '0;
  assign FillTagAddr = tag_q;
  assign FillDone    = (state_q == ST_DONE);
  assign FillBusy    = (state_q != ST_IDLE);

  mem_rsp_in_window: assert property (@(posedge clk) disable iff (!reset_n)
    MemRspValid |-> (state_q == ST_WAIT || state_q == ST_DRAIN))
    else $error("MemRspValid outside WAIT/DRAIN (state %0d)", state_q);

endmodule

// File: tb/tb_icache_fill_ctlr.sv
// Randomized self-checking bench for icache_fill_ctlr with a transaction-level fill model.
module tb_icache_fill_ctlr;

  localparam int WORDS       = 16;
  localparam int ADDR_W      = 32;
  localparam int BLOCK_BYTES = WORDS * 4;

  localparam int AB_REQ_NORDY  = 0;
  localparam int AB_REQ_RDY    = 1;
  localparam int AB_WAIT_NORSP = 2;
  localparam int AB_WAIT_RSP   = 3;
  localparam int AB_RESET      = 4;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     InstrMissF;
  logic [ADDR_W-1:0]        MissAddrF;
  logic                     FlushFill;
  logic                     MemReq;
  logic [ADDR_W-1:0]        MemAddr;
  logic                     MemReady;
  logic                     MemRspValid;
  logic [31:0]              MemRspData;
  logic                     FillWe;
  logic [$clog2(WORDS)-1:0] FillWordIdx;
  logic [31:0]              FillData;
  logic [ADDR_W-1:0]        FillTagAddr;
  logic                     FillDone;
  logic                     FillBusy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  icache_fill_ctlr #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .InstrMissF  (InstrMissF),
    .MissAddrF   (MissAddrF),
    .FlushFill   (FlushFill),
    .MemReq      (MemReq),
    .MemAddr     (MemAddr),
    .MemReady    (MemReady),
    .MemRspValid (MemRspValid),
    .MemRspData  (MemRspData),
    .FillWe      (FillWe),
    .FillWordIdx (FillWordIdx),
    .FillData    (FillData),
    .FillTagAddr (FillTagAddr),
    .FillDone    (FillDone),
    .FillBusy    (FillBusy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Backing memory contents: low byte is 0xA0 + word offset within a 16-word block.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] lo;
    lo = 8'hA0 + 8'(a[5:2]);
    return {a[23:0], 8'h00} | {24'h0, lo};
  endfunction

  // Memory keeps its promised response for a request accepted before a flush.
  task automatic drain(input int lat);
    for (int l = 1; l < lat; l++) begin
      @(negedge clk);
      check_eq("drain_req", MemReq, 1'b0);
      check_eq("drain_busy", FillBusy, 1'b1);
      check_eq("drain_we", FillWe, 1'b0);
      next_cycle();
    end
    MemRspValid = 1'b1;
    MemRspData  = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("drain_rsp_we", FillWe, 1'b0);
    check_eq("drain_done", FillDone, 1'b0);
    next_cycle();
    MemRspValid = 1'b0;
    @(negedge clk);
    check_eq("drain_idle", FillBusy, 1'b0);
    check_eq("drain_nodone", FillDone, 1'b0);
    next_cycle();
  endtask

  // One miss from capture to completion or abort; starts and ends just after a rising edge.
  task automatic run_fill(input logic [31:0] addr, input bit rnd, input int stall_word,
                          input int stall_len, input int abort_word, input int abort_kind);
    int          start;
    int          idx;
    int          stall;
    int          lat;
    int          exp_cycles;
    int          c0;
    logic [31:0] base;
    logic [31:0] a;
    base  = addr - (addr % BLOCK_BYTES);
    start = 0;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
    start = (addr % BLOCK_BYTES) / 4;
`endif
    InstrMissF = 1'b1;
    MissAddrF  = addr;
    FlushFill  = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", FillBusy, 1'b0);
    c0         = cyc;
    exp_cycles = 1;
    next_cycle();
    check_eq("tag_addr", FillTagAddr, base);
    for (int k = 0; k < WORDS; k++) begin
      idx   = (start + k) % WORDS;
      a     = base + 32'(idx * 4);
      stall = rnd ? int'($urandom_range(0, 2)) : ((k == stall_word) ? stall_len : 0);
      lat   = rnd ? int'($urandom_range(1, 3)) : 1;
      for (int s = 0; s < stall; s++) begin
        MemReady = 1'b0;
        @(negedge clk);
        check_eq("stall_req", MemReq, 1'b1);
        check_eq("stall_addr", MemAddr, a);
        check_eq("stall_we", FillWe, 1'b0);
        next_cycle();
      end
      if (k == abort_word && abort_kind == AB_REQ_NORDY) begin
        MemReady  = 1'b0;
        FlushFill = 1'b1;
        @(negedge clk);
        check_eq("wdraw_req", MemReq, 1'b1);
        next_cycle();
        FlushFill  = 1'b0;
        InstrMissF = 1'b0;
        @(negedge clk);
        check_eq("wdraw_idle", FillBusy, 1'b0);
        check_eq("wdraw_noreq", MemReq, 1'b0);
        check_eq("wdraw_done", FillDone, 1'b0);
        next_cycle();
        return;
      end
      MemReady  = 1'b1;
      FlushFill = (k == abort_word && abort_kind == AB_REQ_RDY);
      @(negedge clk);
      check_eq("req", MemReq, 1'b1);
      check_eq("req_addr", MemAddr, a);
      next_cycle();
      MemReady = 1'b0;
      if (FlushFill) begin
        FlushFill  = 1'b0;
        InstrMissF = 1'b0;
        drain(lat);
        return;
      end
      if (k == abort_word && abort_kind == AB_WAIT_NORSP) begin
        FlushFill = 1'b1;
        @(negedge clk);
        check_eq("wflush_we", FillWe, 1'b0);
        next_cycle();
        FlushFill  = 1'b0;
        InstrMissF = 1'b0;
        drain(lat);
        return;
      end
      for (int l = 1; l < lat; l++) begin
        @(negedge clk);
        check_eq("wait_req", MemReq, 1'b0);
        check_eq("wait_we", FillWe, 1'b0);
        next_cycle();
      end
      MemRspValid = 1'b1;
      MemRspData  = mem_word(a);
      if (k == abort_word && abort_kind == AB_RESET) begin
        #1;
        check_eq("pre_rst_we", FillWe, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_we", FillWe, 1'b0);
        check_eq("rst_req", MemReq, 1'b0);
        check_eq("rst_busy", FillBusy, 1'b0);
        check_eq("rst_done", FillDone, 1'b0);
        check_eq("rst_tag", FillTagAddr, 32'h0);
        MemRspValid = 1'b0;
        InstrMissF  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check_eq("post_rst_idle", FillBusy, 1'b0);
        next_cycle();
        return;
      end
      if (k == abort_word && abort_kind == AB_WAIT_RSP) begin
        FlushFill = 1'b1;
        @(negedge clk);
        check_eq("rflush_we", FillWe, 1'b0);
        next_cycle();
        MemRspValid = 1'b0;
        FlushFill   = 1'b0;
        InstrMissF  = 1'b0;
        @(negedge clk);
        check_eq("rflush_idle", FillBusy, 1'b0);
        check_eq("rflush_done", FillDone, 1'b0);
        next_cycle();
        return;
      end
      @(negedge clk);
      check_eq("we", FillWe, 1'b1);
      check_eq("widx", FillWordIdx, idx);
      check_eq("wdata", FillData, mem_word(a));
      next_cycle();
      MemRspValid = 1'b0;
      exp_cycles += stall + 1 + lat;
    end
    InstrMissF = 1'b0;
    FlushFill  = rnd && ($urandom_range(0, 1) == 1);
    @(negedge clk);
    check_eq("done", FillDone, 1'b1);
    check_eq("done_cycles", cyc - c0, exp_cycles);
    next_cycle();
    FlushFill = 1'b0;
    @(negedge clk);
    check_eq("done_pulse", FillDone, 1'b0);
    check_eq("idle_after", FillBusy, 1'b0);
    next_cycle();
  endtask

  initial begin
    reset_n     = 1'b0;
    InstrMissF  = 1'b0;
    MissAddrF   = '0;
    FlushFill   = 1'b0;
    MemReady    = 1'b0;
    MemRspValid = 1'b0;
    MemRspData  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_memreq", MemReq, 1'b0);
    check_eq("rst_memaddr", MemAddr, 32'h0);
    check_eq("rst_fillbusy", FillBusy, 1'b0);
    check_eq("rst_filldone", FillDone, 1'b0);
    check_eq("rst_fillwe", FillWe, 1'b0);
    check_eq("rst_filltag", FillTagAddr, 32'h0);
    reset_n = 1'b1;
    next_cycle();

    // Single-cycle memory baseline, then backpressure on word 3.
    run_fill(32'h0000_1234, 1'b0, -1, 0, -1, 0);
    run_fill(32'h0000_1234, 1'b0, 3, 5, -1, 0);

    // Miss and redirect in the same IDLE cycle must not start a fill.
    InstrMissF = 1'b1;
    MissAddrF  = 32'h0000_2000;
    FlushFill  = 1'b1;
    @(negedge clk);
    check_eq("missflush_idle", FillBusy, 1'b0);
    next_cycle();
    InstrMissF = 1'b0;
    FlushFill  = 1'b0;
    @(negedge clk);
    check_eq("missflush_stay", FillBusy, 1'b0);
    next_cycle();

    // Flush races, then a clean refill from 0x4000.
    run_fill(32'h0000_1234, 1'b0, -1, 0, 2, AB_REQ_RDY);
    run_fill(32'h0000_1234, 1'b0, -1, 0, 5, AB_WAIT_RSP);
    run_fill(32'h0000_4000, 1'b0, -1, 0, -1, 0);
    run_fill(32'h0000_3008, 1'b0, 1, 2, 1, AB_REQ_NORDY);
    run_fill(32'h0000_3008, 1'b0, -1, 0, 9, AB_WAIT_NORSP);
    run_fill(32'h0000_1234, 1'b0, -1, 0, 7, AB_RESET);
    run_fill(32'h0000_1234, 1'b0, -1, 0, -1, 0);

    for (int n = 0; n < 30; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        InstrMissF = 1'b0;
        FlushFill  = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_eq("gap_idle", FillBusy, 1'b0);
        next_cycle();
      end
      FlushFill = 1'b0;
      if ($urandom_range(0, 3) == 0)
        run_fill($urandom, 1'b1, -1, 0, int'($urandom_range(0, WORDS - 1)), int'($urandom_range(0, 3)));
      else
        run_fill($urandom, 1'b1, -1, 0, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
